// File: rtl/booth.sv
`default_nettype none
// ============================================================================
// Module      : booth
// Description : Sequential signed radix-4 Booth multiplier. One start pulse
//               launches an N x N two's-complement multiply that retires
//               N/2 add/shift iterations later into the 2N-bit ans register.
// Revision    : 1.0 - initial release
// ============================================================================
module booth #(
   parameter int N     = 8,
   parameter int alpha = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     data_inM,
   input  logic [N-1:0]     data_inQ,
   output logic [2*N-1:0]   ans
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   localparam logic [alpha-1:0] LAST_CNT = alpha'(N/2 - 1);

   state_t               state;
   state_t               state_next;

   // Two guard bits on A and M keep +/-2M and the running sum exact.
   logic signed [N+1:0]  a;
   logic signed [N+1:0]  mreg;
   logic        [N-1:0]  qreg;
   logic                 q_m1;
   logic [alpha-1:0]     cnt;

   logic [2:0]           triplet;
   logic signed [N+1:0]  operand;
   logic signed [N+1:0]  a_sum;
   logic [2*N+2:0]       shifted;
   logic                 last_iter;

   assign triplet   = {qreg[1], qreg[0], q_m1};
   assign last_iter = (cnt == LAST_CNT);

   // Radix-4 recoding of the low multiplier pair plus the appended bit.
   always_comb begin
      operand = '0;
      case (triplet)
         3'b001, 3'b010: operand = mreg;
         3'b011:         operand = mreg <<< 1;
         3'b100:         operand = -(mreg <<< 1);
         3'b101, 3'b110: operand = -mreg;
         default:        operand = '0;
      endcase
   end

   // Accumulate, then arithmetic-shift {A_sum, Q, q_m1} right by two.
   // The two bits shifted out (Q[0], q_m1) are dropped directly.
   always_comb begin
      a_sum   = a + operand;
      shifted = {{2{a_sum[N+1]}}, a_sum, qreg[N-1:1]};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: launch on start in IDLE, return after the last step.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)     state_next = CALC;
         CALC:    if (last_iter) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Datapath: operand capture on launch, one Booth step per CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a    <= '0;
         mreg <= '0;
         qreg <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
         ans  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a    <= '0;
                  mreg <= {{2{data_inM[N-1]}}, data_inM};
                  qreg <= data_inQ;
                  q_m1 <= 1'b0;
                  cnt  <= '0;
               end
            end
            CALC: begin
               a    <= shifted[2*N+2:N+1];
               qreg <= shifted[N:1];
               q_m1 <= shifted[0];
               cnt  <= cnt + alpha'(1);
               // Product is the low N bits of shifted A above shifted Q.
               if (last_iter) begin
                  ans <= shifted[2*N:1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth
// Description : Self-checking bench for booth (N=8): directed corner cases,
//               start-ignore, async abort, back-to-back launches and random
//               operands compared with plain signed multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   dm;
   logic [N-1:0]   dq;
   logic [2*N-1:0] ans;

   int checks = 0;
   int errors = 0;

   booth #(.N(N), .alpha(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .data_inM (dm),
      .data_inQ (dq),
      .ans      (ans)
   );

   always #5 clk = ~clk;

   // Reference: exact signed product, truncated to 2N bits.
   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
      logic signed [2*N-1:0] sm;
      logic signed [2*N-1:0] sq;
      sm = {{N{m[N-1]}}, m};
      sq = {{N{q[N-1]}}, q};
      return sm * sq;
   endfunction

   task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one multiply; ans must hold its old value through the third
   // edge after launch and show the product just after the fourth.
   task automatic run_mul(input logic [N-1:0] m, input logic [N-1:0] q,
                          input string tag, input bit scramble);
      logic [2*N-1:0] prev;
      @(negedge clk);
      dm = m; dq = q; start = 1'b1;
      prev = ans;
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin dm = N'($urandom); dq = N'($urandom); end
      repeat (N/2 - 1) begin
         @(negedge clk);
         if (scramble) begin dm = N'($urandom); dq = N'($urandom); end
      end
      check({tag, "_hold"}, ans, prev);
      @(negedge clk);
      check(tag, ans, ref_mul(m, q));
   endtask

   initial begin
      logic [N-1:0] m_k;
      logic [N-1:0] q_k;

      rst_n = 1'b0; start = 1'b0; dm = '0; dq = '0;
      repeat (2) @(negedge clk);
      check("reset_ans", ans, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ans", ans, '0);

      // Directed products with hand-derived values.
      run_mul(8'h07, 8'hFA, "7x-6", 1'b0);
      check("7x-6_const", ans, 16'hFFD6);
      run_mul(8'h1F, 8'h27, "31x39", 1'b0);
      check("31x39_const", ans, 16'h04B9);
      repeat (20) @(negedge clk);
      check("31x39_idle_hold", ans, 16'h04B9);
      run_mul(8'h80, 8'h80, "min_x_min", 1'b0);
      check("min_x_min_const", ans, 16'h4000);
      run_mul(8'h80, 8'h7F, "min_x_max", 1'b0);
      check("min_x_max_const", ans, 16'hC080);
      run_mul(8'h00, 8'hA5, "zero_x_a5", 1'b0);
      check("zero_x_a5_const", ans, 16'h0000);

      // start pulse during CALC must be ignored.
      @(negedge clk);
      dm = 8'h07; dq = 8'hFA; start = 1'b1;
      @(negedge clk);                 // after launch edge
      start = 1'b0;
      @(negedge clk);                 // after edge 1
      @(negedge clk);                 // after edge 2
      dm = 8'h01; dq = 8'h01; start = 1'b1;
      @(negedge clk);                 // after edge 3
      start = 1'b0;
      check("ignore_hold", ans, 16'h0000);
      @(negedge clk);                 // after edge 4
      check("ignore_result", ans, 16'hFFD6);
      repeat (6) @(negedge clk);
      check("ignore_no_relaunch", ans, 16'hFFD6);
      run_mul(8'hFD, 8'h09, "after_ignore", 1'b0);

      // Asynchronous abort in the middle of a calculation.
      run_mul(8'h07, 8'hFA, "pre_abort", 1'b0);
      @(negedge clk);
      dm = 8'h1F; dq = 8'h27; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("abort_immediate", ans, '0);
      repeat (2) @(negedge clk);
      check("abort_held", ans, '0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_no_result", ans, '0);
      run_mul(8'h03, 8'h05, "3x5_after_abort", 1'b0);
      check("3x5_const", ans, 16'h000F);

      // start held high: relaunch every N/2+1 edges with fresh operands.
      @(negedge clk);
      m_k = N'($urandom); q_k = N'($urandom);
      dm = m_k; dq = q_k; start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         repeat (N/2 + 1) @(negedge clk);
         check($sformatf("b2b_%0d", k), ans, ref_mul(m_k, q_k));
         m_k = N'($urandom); q_k = N'($urandom);
         dm = m_k; dq = q_k;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Random operands; inputs scrambled after each launch.
      for (int i = 0; i < 40; i++) begin
         run_mul(N'($urandom), N'($urandom), $sformatf("rand_%0d", i), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/booth.md
Name: booth

Overview:
- Sequential signed radix-4 Booth multiplier: two's-complement N-bit M (multiplicand) × N-bit Q (multiplier) → 2N-bit signed product.
- One start pulse launches one multiplication; it takes N/2 add/shift iterations.
- Standalone arithmetic leaf block, used wherever a small-area multi-cycle multiply is acceptable.

Parameters:
- N, 8, operand width in bits; must be even and ≥ 4.
- alpha, 3, iteration-counter width in bits; must satisfy 2^alpha ≥ N/2 + 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sampled on rising clk; high in IDLE launches a multiply.
- data_inM  input  N  signed multiplicand; captured on the launching edge only.
- data_inQ  input  N  signed multiplier; captured on the launching edge only.
- ans  output  2N  signed product register; holds the last completed result.

Behaviour:
- Reset (async, rst_n low) clears all of the following to 0 immediately, regardless of clk: FSM→IDLE, ans, accumulator A, multiplier register Q, appended bit q_m1, M register, counter.
- Reset asserted mid-calculation aborts it; ans stays 0 until the next completed multiply.
- Registers:
  - A: N+2 bits, signed.
  - Mreg: N+2 bits, data_inM sign-extended.
  - Qreg: N bits.
  - q_m1: 1 bit.
  - cnt: alpha bits.
- FSM states:
  - IDLE: on an edge with start=1, load A=0, Mreg=sext(data_inM), Qreg=data_inQ, q_m1=0, cnt=0; go to CALC. With start=0, hold.
  - CALC: each edge performs one iteration and increments cnt; start is ignored.
- Iteration step:
  - Recode triplet {Qreg[1],Qreg[0],q_m1}: 000/111→0, 001/010→+M, 011→+2M, 100→−2M, 101/110→−M.
  - A_sum = A + operand, computed at N+2 bits; 2M = Mreg<<1.
  - Arithmetic right shift of {A_sum,Qreg,q_m1} by 2, sign-filling from A_sum MSB; results go to A, Qreg, q_m1.
- Completion:
  - On the iteration where cnt == N/2−1, ans ← {A_shifted[N−1:0], Qreg_shifted} (full 2N-bit product) and FSM → IDLE.
- Latency: start sampled at edge E0; ans updated at edge E0+N/2 (N=8: 4th edge after launch); ans changes at no other time.
- ans holds its value indefinitely between completions; there is no done output.
- start held high continuously: the multiply completes and returns to IDLE, and the next edge relaunches with the operands present on that edge.
- Operand inputs may change freely after the launching edge without affecting the result.
- Result is exact for all operand pairs, including −2^(N−1) × −2^(N−1) = +2^(2N−2), which fits in 2N signed bits.

Test Plan:
- Reset, then M=8'h07, Q=8'hFA (7 × −6), start high for one edge → ans=16'hFFD6 (−42) on the 4th edge after the launching edge; ans=0 before that.
- M=8'h1F, Q=8'h27 (31 × 39) → ans=16'h04B9 (1209); then hold start low for 20 cycles → ans remains 16'h04B9.
- Corner cases: M=8'h80, Q=8'h80 → ans=16'h4000; M=8'h80, Q=8'h7F → ans=16'hC080; M=8'h00, Q=8'hA5 → ans=16'h0000.
- Launch 7 × −6, then 2 edges later set M=Q=8'h01 and pulse start → start ignored during CALC; ans=16'hFFD6 at the expected edge; a new launch works afterwards.
- Launch 31 × 39, pull rst_n low between clock edges mid-calculation → ans=0 immediately and stays 0 with no result appearing; after release, a new 3 × 5 launch → ans=16'h000F.
- Hold start high, changing operands every 5 cycles → ans updates once per multiply with the product of the operands present at each launching edge.
